amdemod_cfgseq: RTL and testbench
=================================

AMDEMOD_CFGSEQ -- requirements
Module: amdemod_cfgseq

Purpose: Wishbone-master configuration sequencer for the AM demodulator bus slave. On one start command it performs these writes in order:
- gain
- PLL step
- filter reset
- NCOEFFS audio-filter coefficient writes, fetched from a coefficient memory
- PLL loop coefficient

Interface
REQ-001 SHALL provide parameter NCOEFFS, default 666, number of coefficient writes per sequence.
REQ-002 SHALL provide parameter LGNCOEFF, default 10, coefficient address width; 2^LGNCOEFF >= NCOEFFS.
REQ-003 i_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_start  input  1  one-cycle request to begin a sequence.
REQ-006 i_abort  input  1  terminate any sequence in progress.
REQ-007 i_gain  input  16  gain value, written to slave address 0.
REQ-008 i_pll_step  input  32  PLL step word, written to slave address 1.
REQ-009 i_lgcoeff  input  5  PLL loop coefficient, written to slave address 3.
REQ-010 o_coef_addr  output  LGNCOEFF  coefficient memory read address.
REQ-011 i_coef_data  input  16  coefficient read data, valid exactly one cycle after o_coef_addr.
REQ-012 o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  Wishbone pipelined master controls.
REQ-013 o_wb_addr  output  2  Wishbone slave address.
REQ-014 o_wb_data  output  32  Wishbone write data.
REQ-015 o_wb_sel  output  4  Wishbone byte selects.
REQ-016 i_wb_stall, i_wb_ack, i_wb_err  input  1 each  Wishbone slave responses.
REQ-017 o_busy  output  1  high while a sequence is active.
REQ-018 o_done  output  1  one-cycle completion pulse.
REQ-019 o_err  output  1  sticky error flag, cleared by the next accepted start.

Function
REQ-020 i_gain, i_pll_step and i_lgcoeff SHALL be latched on the cycle i_start is accepted; later changes SHALL not affect the running sequence.
REQ-021 i_start SHALL be accepted only in IDLE; i_start while o_busy SHALL be ignored.
REQ-022 The state machine SHALL have states IDLE, FETCH, REQ and WAIT, plus a step register with values GAIN, PLL, FRST, COEF and LGC.
REQ-023 An accepted start SHALL enter REQ with step GAIN and assert o_busy on the next cycle.
REQ-024 Write contents per step SHALL be:
- GAIN: addr 0, data {16'h0, gain}
- PLL: addr 1, data pll_step
- FRST: addr 2, data 32'h8000_0000
- COEF: addr 2, data {16'h0, coef}
- LGC: addr 3, data {27'h0, lgcoeff}
REQ-025 In every write o_wb_we SHALL be 1 and o_wb_sel SHALL be 4'hF.
REQ-026 In REQ, cyc and stb SHALL be high with address and data stable; leave REQ for WAIT on the first cycle with !i_wb_stall, dropping stb in the following cycle.
REQ-027 In WAIT, cyc SHALL stay high and stb low; on i_wb_ack, drop cyc and advance to the next step. At most one write SHALL be outstanding.
REQ-028 After FRST completes, the coefficient index SHALL reset to 0.
REQ-029 For each COEF write the block SHALL pass through FETCH for exactly one cycle: drive o_coef_addr = index, then capture i_coef_data into the data register on entry to REQ.
REQ-030 After a COEF ack with index == NCOEFFS-1, advance to LGC; otherwise increment the index and return to FETCH.
REQ-031 After the LGC ack: return to IDLE, drop o_busy, and pulse o_done for one cycle.
REQ-032 i_wb_err in REQ or WAIT SHALL drop cyc/stb the next cycle, set o_err, return to IDLE, and pulse o_done.
REQ-033 i_abort in any non-IDLE state SHALL drop cyc/stb the next cycle and return to IDLE without o_done; abort SHALL have priority over ack and err in the same cycle.
REQ-034 An ack or err received while in IDLE SHALL be ignored.
REQ-035 o_coef_addr SHALL hold its value outside FETCH.
REQ-036 Minimum sequence length SHALL be 2*(NCOEFFS+4) + NCOEFFS + 1 cycles, assuming zero stall and one-cycle ack.

Reset
REQ-037 On i_reset (asynchronous, active-high), all of the following SHALL be 0 and the state SHALL be IDLE:
- o_wb_cyc, o_wb_stb, o_busy, o_done, o_err
- o_coef_addr, the coefficient index
- o_wb_addr, o_wb_data
REQ-038 Reset asserted mid-sequence SHALL release the bus immediately, without waiting for an outstanding ack.

Structure
REQ-039 Slave address constants (GAIN=0, PLL=1, FILTER=2, LGCOEFF=3), the FRST data word and the state/step encodings SHALL reside in the shared package amdemod_pkg.
REQ-040 The block SHALL be a single module; no sub-module is required.

Verification
REQ-041 Bench with NCOEFFS=4, memory {1,2,3,4}: start with gain=16'h4000, step=32'h0040_0000, lgc=2; slave has no stall and one-cycle ack. Required:
- 8 writes in order (0,16'h4000), (1,32'h0040_0000), (2,32'h8000_0000), (2,1), (2,2), (2,3), (2,4), (3,2)
- o_done pulses once
- o_err stays 0
REQ-042 Slave stalls 3 cycles on every write: stb held 4 cycles per write, each write's address/data unchanged until accepted, same write sequence as REQ-041.
REQ-043 i_wb_err on the 3rd write: cyc drops the next cycle, o_err=1, o_done pulses, no further writes; the next start clears o_err.
REQ-044 i_abort coincident with ack on the 5th write: bus released, IDLE, no o_done, no further writes.
REQ-045 i_start during busy, and inputs changed mid-sequence: neither affects the writes; i_reset asserted while waiting in WAIT: cyc falls asynchronously and all outputs read 0.

Source files
------------

// File: rtl/amdemod_pkg.sv
`default_nettype none
// ============================================================================
// Package   : amdemod_pkg
// Purpose   : Shared constants for the AM demodulator configuration path:
//             slave register map, filter-reset word, sequencer encodings.
// Revision  : 1.0
// ============================================================================
package amdemod_pkg;

  // Slave register map
  localparam logic [1:0] ADDR_GAIN    = 2'd0;
  localparam logic [1:0] ADDR_PLL     = 2'd1;
  localparam logic [1:0] ADDR_FILTER  = 2'd2;
  localparam logic [1:0] ADDR_LGCOEFF = 2'd3;

  // Writing this word to the filter address resets the audio filter
  localparam logic [31:0] FRST_WORD = 32'h8000_0000;

  // Bus-phase state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_REQ   = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  // Configuration step encoding
  localparam logic [2:0] STEP_GAIN = 3'd0;
  localparam logic [2:0] STEP_PLL  = 3'd1;
  localparam logic [2:0] STEP_FRST = 3'd2;
  localparam logic [2:0] STEP_COEF = 3'd3;
  localparam logic [2:0] STEP_LGC  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/amdemod_cfgseq_if.sv
`default_nettype none
// ============================================================================
// Interface : amdemod_cfgseq_if
// Purpose   : Pipelined Wishbone write port between the configuration
//             sequencer (master) and the AM demodulator slave.
// Revision  : 1.0
// ============================================================================
interface amdemod_cfgseq_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [1:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_stall, i_wb_ack, i_wb_err
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_stall, i_wb_ack, i_wb_err
  );
endinterface
`default_nettype wire

// File: rtl/amdemod_cfgseq.sv
`default_nettype none
// ============================================================================
// Module    : amdemod_cfgseq
// Purpose   : On a start command, writes gain, PLL step, filter reset, the
//             audio-filter coefficients (read from a coefficient memory) and
//             the PLL loop coefficient to the demodulator over Wishbone.
// Revision  : 1.0
// ============================================================================
module amdemod_cfgseq
  import amdemod_pkg::*;
#(
  parameter int NCOEFFS  = 666,
  parameter int LGNCOEFF = 10
) (
  input  wire logic                i_clk,
  input  wire logic                i_reset,
  input  wire logic                i_start,
  input  wire logic                i_abort,
  input  wire logic [15:0]         i_gain,
  input  wire logic [31:0]         i_pll_step,
  input  wire logic [4:0]          i_lgcoeff,
  output logic      [LGNCOEFF-1:0] o_coef_addr,
  input  wire logic [15:0]         i_coef_data,
  amdemod_cfgseq_if.master         wb,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
);

  logic [1:0]          state;
  logic [2:0]          step;
  logic [LGNCOEFF-1:0] idx;
  logic [15:0]         gain_q;
  logic [31:0]         pll_q;
  logic [4:0]          lgc_q;
  logic                cyc;
  logic                stb;
  logic [1:0]          addr;
  logic [31:0]         data_q;
  logic                coef_live;
  logic                last_coef;
  logic                bus_err;
  logic                stop;

  // Coefficient data only arrives during the first REQ cycle, so it is
  // forwarded straight to the bus then and held in data_q afterwards.
  assign wb.o_wb_cyc  = cyc;
  assign wb.o_wb_stb  = stb;
  assign wb.o_wb_we   = 1'b1;
  assign wb.o_wb_sel  = 4'hF;
  assign wb.o_wb_addr = addr;
  assign wb.o_wb_data = coef_live ? {16'h0, i_coef_data} : data_q;

  assign last_coef = (idx == LGNCOEFF'(NCOEFFS - 1));
  assign bus_err   = wb.i_wb_err && ((state == ST_REQ) || (state == ST_WAIT));
  assign stop      = (state != ST_IDLE) && (i_abort || bus_err);

  // Sequencer: one write in flight at a time, abort outranks err and ack
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      step        <= STEP_GAIN;
      idx         <= '0;
      o_coef_addr <= '0;
      gain_q      <= '0;
      pll_q       <= '0;
      lgc_q       <= '0;
      cyc         <= 1'b0;
      stb         <= 1'b0;
      addr        <= '0;
      data_q      <= '0;
      coef_live   <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (stop) begin
        state     <= ST_IDLE;
        cyc       <= 1'b0;
        stb       <= 1'b0;
        coef_live <= 1'b0;
        o_busy    <= 1'b0;
        if (!i_abort) begin
          o_err  <= 1'b1;
          o_done <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              gain_q <= i_gain;
              pll_q  <= i_pll_step;
              lgc_q  <= i_lgcoeff;
              o_err  <= 1'b0;
              o_busy <= 1'b1;
              state  <= ST_REQ;
              step   <= STEP_GAIN;
              cyc    <= 1'b1;
              stb    <= 1'b1;
              addr   <= ADDR_GAIN;
              data_q <= {16'h0, i_gain};
            end
          end
          ST_FETCH: begin
            state     <= ST_REQ;
            step      <= STEP_COEF;
            cyc       <= 1'b1;
            stb       <= 1'b1;
            addr      <= ADDR_FILTER;
            coef_live <= 1'b1;
          end
          ST_REQ: begin
            if (coef_live) begin
              data_q    <= {16'h0, i_coef_data};
              coef_live <= 1'b0;
            end
            if (!wb.i_wb_stall) begin
              stb   <= 1'b0;
              state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (wb.i_wb_ack) begin
              case (step)
                STEP_GAIN: begin
                  step   <= STEP_PLL;
                  state  <= ST_REQ;
                  stb    <= 1'b1;
                  addr   <= ADDR_PLL;
                  data_q <= pll_q;
                end
                STEP_PLL: begin
                  step   <= STEP_FRST;
                  state  <= ST_REQ;
                  stb    <= 1'b1;
                  addr   <= ADDR_FILTER;
                  data_q <= FRST_WORD;
                end
                STEP_FRST: begin
                  idx         <= '0;
                  o_coef_addr <= '0;
                  state       <= ST_FETCH;
                  cyc         <= 1'b0;
                end
                STEP_COEF: begin
                  if (last_coef) begin
                    step   <= STEP_LGC;
                    state  <= ST_REQ;
                    stb    <= 1'b1;
                    addr   <= ADDR_LGCOEFF;
                    data_q <= {27'h0, lgc_q};
                  end else begin
                    idx         <= idx + LGNCOEFF'(1);
                    o_coef_addr <= idx + LGNCOEFF'(1);
                    state       <= ST_FETCH;
                    cyc         <= 1'b0;
                  end
                end
                default: begin
                  state  <= ST_IDLE;
                  cyc    <= 1'b0;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                end
              endcase
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amdemod_cfgseq.sv
`default_nettype none
// ============================================================================
// Module    : tb_amdemod_cfgseq
// Purpose   : Self-checking bench for amdemod_cfgseq with a Wishbone slave
//             model, a registered coefficient memory and a write-list model.
// Revision  : 1.0
// ============================================================================
module tb_amdemod_cfgseq;
  localparam int N  = 4;
  localparam int LG = 2;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          stbs;
    bit          stable;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   gain = '0;
  logic [31:0]   pstep = '0;
  logic [4:0]    lgc = '0;
  logic [LG-1:0] coef_addr;
  logic [15:0]   coef_data = '0;
  logic          busy, done, err;
  logic [15:0]   mem [N];

  logic          ack_r, err_r;
  int            stall_n = 0;
  int            err_at = 0;
  int            wait_cnt = 0;
  logic [1:0]    fa;
  logic [31:0]   fd;
  wr_t           wlog[$];
  wr_t           expq[$];

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int done_cnt = 0;
  int err_hi = 0;
  int st_cyc = 0;

  amdemod_cfgseq_if bus ();

  amdemod_cfgseq #(.NCOEFFS(N), .LGNCOEFF(LG)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_abort    (abort),
    .i_gain     (gain),
    .i_pll_step (pstep),
    .i_lgcoeff  (lgc),
    .o_coef_addr(coef_addr),
    .i_coef_data(coef_data),
    .wb         (bus),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // Coefficient memory: data valid one cycle after the address
  always @(posedge clk) coef_data <= mem[coef_addr];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave: optional stall per write, ack (or err) one cycle after acceptance
  assign bus.i_wb_stall = bus.o_wb_cyc && bus.o_wb_stb && (wait_cnt < stall_n);
  assign bus.i_wb_ack   = ack_r;
  assign bus.i_wb_err   = err_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      wait_cnt <= 0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      if (bus.o_wb_cyc && bus.o_wb_stb) begin
        if (wait_cnt < stall_n) begin
          if (wait_cnt == 0) begin
            fa <= bus.o_wb_addr;
            fd <= bus.o_wb_data;
          end
          wait_cnt <= wait_cnt + 1;
        end else begin : accept
          wr_t rec;
          rec.addr   = bus.o_wb_addr;
          rec.data   = bus.o_wb_data;
          rec.stbs   = wait_cnt + 1;
          rec.stable = (wait_cnt == 0) || (fa == bus.o_wb_addr && fd == bus.o_wb_data);
          wlog.push_back(rec);
          wait_cnt <= 0;
          if (err_at == wlog.size()) err_r <= 1'b1;
          else                       ack_r <= 1'b1;
        end
      end
    end
  end

  // Output monitors
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_hi++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected write list straight from the configuration order
  task automatic build_exp(input logic [15:0] g, input logic [31:0] s, input logic [4:0] l);
    wr_t e;
    expq.delete();
    e.stbs = stall_n + 1;
    e.stable = 1'b1;
    e.addr = 2'd0; e.data = {16'h0, g};    expq.push_back(e);
    e.addr = 2'd1; e.data = s;             expq.push_back(e);
    e.addr = 2'd2; e.data = 32'h8000_0000; expq.push_back(e);
    for (int i = 0; i < N; i++) begin
      e.addr = 2'd2; e.data = {16'h0, mem[i]}; expq.push_back(e);
    end
    e.addr = 2'd3; e.data = {27'h0, l};    expq.push_back(e);
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_nwr"}, wlog.size(), expq.size());
    for (int i = 0; i < expq.size() && i < wlog.size(); i++) begin
      chk($sformatf("%s_w%0d_addr", tag, i), wlog[i].addr, expq[i].addr);
      chk($sformatf("%s_w%0d_data", tag, i), wlog[i].data, expq[i].data);
      chk($sformatf("%s_w%0d_stbs", tag, i), wlog[i].stbs, expq[i].stbs);
      chk($sformatf("%s_w%0d_stable", tag, i), wlog[i].stable, 1);
    end
  endtask

  task automatic clear_obs();
    wlog.delete();
    done_cnt = 0;
    err_hi = 0;
  endtask

  task automatic pulse_start(input logic [15:0] g, input logic [31:0] s, input logic [4:0] l);
    @(negedge clk);
    gain = g; pstep = s; lgc = l;
    start = 1'b1;
    st_cyc = cyc_n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int len);
    int i;
    len = -1;
    for (i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    chk({tag, "_done_seen"}, done, 1);
    len = cyc_n - st_cyc;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cyc"},  bus.o_wb_cyc, 0);
    chk({tag, "_stb"},  bus.o_wb_stb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"},  err, 0);
    chk({tag, "_caddr"}, coef_addr, 0);
    chk({tag, "_addr"}, bus.o_wb_addr, 0);
    chk({tag, "_data"}, bus.o_wb_data, 0);
  endtask

  initial begin
    int len;
    int i;
    logic [15:0] g;
    logic [31:0] s;
    logic [4:0]  l;

    for (int k = 0; k < N; k++) mem[k] = 16'(k + 1);

    // Reset state
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed sequence, no stall: order, length, single done, no err
    stall_n = 0; err_at = 0;
    clear_obs();
    build_exp(16'h4000, 32'h0040_0000, 5'd2);
    pulse_start(16'h4000, 32'h0040_0000, 5'd2);
    wait_done("basic", 200, len);
    chk("basic_len", len, 2 * (N + 4) + N + 1);
    compare_log("basic");
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_err_hi", err_hi, 0);
    chk("basic_busy_after", busy, 0);

    // Three-cycle stall on every write
    stall_n = 3;
    clear_obs();
    build_exp(16'h4000, 32'h0040_0000, 5'd2);
    pulse_start(16'h4000, 32'h0040_0000, 5'd2);
    wait_done("stall", 400, len);
    compare_log("stall");
    chk("stall_done_cnt", done_cnt, 1);

    // Randomized contents and stall depths
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) mem[k] = 16'($urandom);
      stall_n = $urandom_range(0, 2);
      g = 16'($urandom); s = $urandom; l = 5'($urandom);
      clear_obs();
      build_exp(g, s, l);
      pulse_start(g, s, l);
      wait_done($sformatf("rnd%0d", r), 400, len);
      compare_log($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_done_cnt", r), done_cnt, 1);
    end

    // Bus error on the third write
    stall_n = 0; err_at = 3;
    clear_obs();
    pulse_start(16'h1234, 32'hCAFE_0001, 5'd7);
    for (i = 0; i < 100 && err_r !== 1'b1; i++) @(negedge clk);
    chk("err_seen", err_r, 1);
    @(negedge clk);
    chk("err_cyc", bus.o_wb_cyc, 0);
    chk("err_flag", err, 1);
    chk("err_done", done, 1);
    chk("err_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("err_nwr", wlog.size(), 3);
    chk("err_done_cnt", done_cnt, 1);
    chk("err_sticky", err, 1);
    err_at = 0;
    clear_obs();
    g = 16'($urandom); s = $urandom; l = 5'($urandom);
    build_exp(g, s, l);
    pulse_start(g, s, l);
    chk("err_cleared", err, 0);
    wait_done("after_err", 200, len);
    compare_log("after_err");

    // Abort coincident with ack of the fifth write
    clear_obs();
    pulse_start(16'h0101, 32'h0202_0303, 5'd4);
    for (i = 0; i < 100 && !(ack_r === 1'b1 && wlog.size() == 5); i++) @(negedge clk);
    chk("abort_ack5", ack_r, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_cyc", bus.o_wb_cyc, 0);
    chk("abort_stb", bus.o_wb_stb, 0);
    chk("abort_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_nwr", wlog.size(), 5);

    // Start while busy and input changes mid-sequence are ignored
    stall_n = 1;
    clear_obs();
    g = 16'($urandom); s = $urandom; l = 5'($urandom);
    build_exp(g, s, l);
    pulse_start(g, s, l);
    repeat (6) @(negedge clk);
    pulse_start(~g, ~s, ~l);
    gain = 16'($urandom); pstep = $urandom; lgc = 5'($urandom);
    wait_done("busy_start", 400, len);
    compare_log("busy_start");
    chk("busy_start_done_cnt", done_cnt, 1);

    // Asynchronous reset while waiting for an ack
    stall_n = 2;
    clear_obs();
    pulse_start(16'h5555, 32'hAAAA_5555, 5'd9);
    for (i = 0; i < 100 && !(bus.o_wb_cyc === 1'b1 && bus.o_wb_stb === 1'b0); i++) @(negedge clk);
    chk("rstw_in_wait", {bus.o_wb_cyc, bus.o_wb_stb}, 2'b10);
    #1 rst = 1'b1;
    #1;
    check_all_zero("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_wait_idle_busy", busy, 0);
    chk("rst_wait_idle_cyc", bus.o_wb_cyc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
